// File: rtl/a5_pkg.sv
// Shared types and widths for the A5/1 keystream consumer.
package a5_pkg;

   localparam int KEY_WIDTH           = 64;
   localparam int WORD_WIDTH          = 32;
   localparam int FRAME_WIDTH_DEFAULT = 22;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/a5_out_reg.sv
// One-entry valid/ready output register carrying a data word and its last flag.
module a5_out_reg
   import a5_pkg::*;
#(
   parameter int DW = WORD_WIDTH
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          load,
   input  logic [DW-1:0] d_data,
   input  logic          d_last,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_last,
   output logic          can_load
);

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   logic          last_q, last_d;

   always_comb begin
      valid_d  = valid_q;
      data_d   = data_q;
      last_d   = last_q;
      // The slot is free for a new word when empty or being drained this cycle.
      can_load = !valid_q || out_ready;
      if (load) begin
         valid_d = 1'b1;
         data_d  = d_data;
         last_d  = d_last;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_last  = last_q;

endmodule

// File: rtl/a5_stream_cipher.sv
// A5/1 keystream consumer: XORs buffered keystream into a word stream and
// drives the buffer's load/key/frame controls, rekeying with frame+1 per frame.
module a5_stream_cipher
   import a5_pkg::*;
#(
   parameter int WPF_WIDTH   = 8,
   parameter int FRAME_WIDTH = FRAME_WIDTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic [KEY_WIDTH-1:0]   key,
   input  logic [FRAME_WIDTH-1:0] frame_init,
   input  logic [WPF_WIDTH-1:0]   words_per_frame,
   output logic                   busy,
   output logic [FRAME_WIDTH-1:0] cur_frame,
   output logic                   ks_load,
   output logic [KEY_WIDTH-1:0]   ks_key,
   output logic [FRAME_WIDTH-1:0] ks_frame,
   input  logic [WORD_WIDTH-1:0]  ks_data,
   input  logic                   ks_empty,
   output logic                   ks_rd_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD_WIDTH-1:0]  in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORD_WIDTH-1:0]  out_data,
   output logic                   out_last
);

   state_e                 state_q, state_d;
   logic [KEY_WIDTH-1:0]   key_q, key_d;
   logic [FRAME_WIDTH-1:0] frame_q, frame_d;
   logic [WPF_WIDTH-1:0]   wpf_q, wpf_d;
   logic [WPF_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   ks_load_q, ks_load_d;
   logic                   can_accept;
   logic                   fire;
   logic                   relatch;

   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      frame_d  = frame_q;
      wpf_d    = wpf_q;
      cnt_d    = cnt_q;
      relatch  = 1'b0;
      in_ready = (state_q == ST_RUN) && !ks_empty && can_accept && !start && !stop;
      fire     = in_valid && in_ready;

      case (state_q)
         ST_IDLE: relatch = start && !stop;
         ST_LOAD: state_d = stop ? ST_IDLE : ST_RUN;
         ST_RUN: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (start) begin
               relatch = 1'b1;
            end else if (fire) begin
               // Frame boundary: the boundary word still goes out, then rekey.
               if (wpf_q != '0 && cnt_q == wpf_q - WPF_WIDTH'(1)) begin
                  cnt_d   = '0;
                  frame_d = frame_q + FRAME_WIDTH'(1);
                  state_d = ST_LOAD;
               end else begin
                  cnt_d = cnt_q + WPF_WIDTH'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (relatch) begin
         state_d = ST_LOAD;
         key_d   = key;
         frame_d = frame_init;
         wpf_d   = words_per_frame;
         cnt_d   = '0;
      end

      ks_load_d = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         key_q     <= '0;
         frame_q   <= '0;
         wpf_q     <= '0;
         cnt_q     <= '0;
         ks_load_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         key_q     <= key_d;
         frame_q   <= frame_d;
         wpf_q     <= wpf_d;
         cnt_q     <= cnt_d;
         ks_load_q <= ks_load_d;
      end
   end

   a5_out_reg #(
      .DW (WORD_WIDTH)
   ) u_out_reg (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (fire),
      .d_data    (in_data ^ ks_data),
      .d_last    (in_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .can_load  (can_accept)
   );

   assign busy      = (state_q != ST_IDLE);
   assign cur_frame = frame_q;
   assign ks_frame  = frame_q;
   assign ks_key    = key_q;
   assign ks_load   = ks_load_q;
   assign ks_rd_en  = fire;

endmodule

// File: tb/tb_a5_stream_cipher.sv
// Scoreboard bench for a5_stream_cipher with a behavioural keystream buffer.
module tb_a5_stream_cipher;

   localparam int WPF_W = 8;
   localparam int FW    = 22;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [63:0]       key = '0;
   logic [FW-1:0]     frame_init = '0;
   logic [WPF_W-1:0]  wpf = '0;
   logic              busy;
   logic [FW-1:0]     cur_frame;
   logic              ks_load;
   logic [63:0]       ks_key;
   logic [FW-1:0]     ks_frame;
   logic [31:0]       ks_data = '0;
   logic              ks_empty;
   logic              ks_rd_en;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_data = '0;
   logic              in_last = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [31:0]       out_data;
   logic              out_last;

   always #5 clk = ~clk;

   a5_stream_cipher #(
      .WPF_WIDTH   (WPF_W),
      .FRAME_WIDTH (FW)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .stop            (stop),
      .key             (key),
      .frame_init      (frame_init),
      .words_per_frame (wpf),
      .busy            (busy),
      .cur_frame       (cur_frame),
      .ks_load         (ks_load),
      .ks_key          (ks_key),
      .ks_frame        (ks_frame),
      .ks_data         (ks_data),
      .ks_empty        (ks_empty),
      .ks_rd_en        (ks_rd_en),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_last         (in_last),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_last        (out_last)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Keystream word i of a frame, as an ideal generator would produce it.
   function automatic logic [31:0] ksw(input logic [FW-1:0] f, input int unsigned i);
      return (32'(f) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B) ^ 32'h5A5AC3C3;
   endfunction

   // ---------------- keystream buffer model ----------------
   logic [31:0]  kq[$];
   int           kcnt = 0;
   logic         force_empty = 1'b0;
   logic [FW-1:0] bf = '0;
   int unsigned  bidx = 0;
   bit           buf_live = 1'b0;
   int           rd_cnt = 0;
   int           load_cnt = 0;

   assign ks_empty = force_empty | (kcnt == 0);

   always @(posedge clk) begin : buf_model
      logic          ld, pop;
      logic [FW-1:0] fr;
      ld  = ks_load;
      pop = ks_rd_en;
      fr  = ks_frame;
      #1;
      if (ld) begin
         kq.delete();
         bf       = fr;
         bidx     = 0;
         buf_live = 1'b1;
      end else if (pop) begin
         rd_cnt++;
         check("rd_nonempty", (kq.size() == 0) ? 0 : 1, 1);
         if (kq.size() != 0) void'(kq.pop_front());
      end
      while (buf_live && kq.size() < 4) begin
         kq.push_back(ksw(bf, bidx));
         bidx++;
      end
      kcnt    = kq.size();
      ks_data = (kcnt > 0) ? kq[0] : '0;
   end

   always @(negedge clk) if (ks_load) load_cnt++;

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [31:0] d;
      logic        l;
   } exp_t;

   exp_t          exp_q[$];
   int unsigned   m_k = 0;
   logic [FW-1:0] m_fi = '0;
   int unsigned   m_wpf = 0;

   always @(negedge clk) begin : in_mon
      logic [FW-1:0] f;
      int unsigned   idx;
      exp_t          e;
      if (reset_n && in_valid && in_ready) begin
         f     = m_fi + FW'((m_wpf == 0) ? 0 : m_k / m_wpf);
         idx   = (m_wpf == 0) ? m_k : m_k % m_wpf;
         e.d   = in_data ^ ksw(f, idx);
         e.l   = in_last;
         exp_q.push_back(e);
         m_k++;
      end
   end

   always @(negedge clk) begin : out_mon
      exp_t e;
      if (reset_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("out_unexpected", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.d);
            check("out_last", out_last, e.l);
         end
      end
   end

   // ---------------- out_ready driver ----------------
   bit   bp_en = 1'b0;
   logic rdy_val = 1'b1;

   always @(posedge clk) begin
      #1;
      out_ready = bp_en ? ($urandom_range(0, 3) != 0) : rdy_val;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input int n, input bit zero, input bit gaps);
      int t;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = zero ? 32'h0 : $urandom;
         in_last  = (i == n - 1);
         t = 0;
         forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 200) begin
               check("send_timeout", 0, 1);
               in_valid = 1'b0;
               in_last  = 1'b0;
               return;
            end
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic do_start(input logic [63:0] k, input logic [FW-1:0] fi, input logic [WPF_W-1:0] w);
      key        = k;
      frame_init = fi;
      wpf        = w;
      start      = 1'b1;
      m_fi       = fi;
      m_wpf      = int'(w);
      m_k        = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("start_ks_load", ks_load, 1);
      check("start_ks_frame", ks_frame, fi);
      check("start_ks_key", ks_key, k);
   endtask

   task automatic drain();
      int t;
      rdy_val = 1'b1;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 300) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin : global_timeout
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin : main
      int l0, r0, c;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_ks_load", ks_load, 0);
      check("rst_ks_rd_en", ks_rd_en, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_cur_frame", cur_frame, 0);
      check("rst_ks_key", ks_key, 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic session, no rekey, zero plaintext exposes the keystream.
      l0 = load_cnt;
      do_start(64'h0123456789ABCDEF, 22'h134, 8'd0);
      check("busy_after_start", busy, 1);
      @(posedge clk);
      #1;
      check("ks_load_one_cycle", ks_load, 0);
      check("load_pulses_start", load_cnt - l0, 1);
      r0 = rd_cnt;
      send(4, 1'b1, 1'b0);
      drain();
      check("pops_four", rd_cnt - r0, 4);

      // Rekey every 3 words across 7 words.
      l0 = load_cnt;
      r0 = rd_cnt;
      do_start(64'h0123456789ABCDEF, 22'h134, 8'd3);
      send(7, 1'b0, 1'b0);
      drain();
      check("rekey_loads", load_cnt - l0, 3);
      check("rekey_frame", cur_frame, 22'h136);
      check("rekey_pops", rd_cnt - r0, 7);

      // Frame counter wrap at all-ones.
      do_start(64'hFEEDFACECAFEBEEF, 22'h3FFFFF, 8'd1);
      send(1, 1'b0, 1'b0);
      drain();
      check("wrap_frame0", cur_frame, 22'h000000);
      send(1, 1'b0, 1'b0);
      drain();
      check("wrap_frame1", cur_frame, 22'h000001);

      // Output backpressure holds exactly one word.
      rdy_val = 1'b0;
      do_start({$urandom, $urandom}, 22'h2A5, 8'd0);
      r0 = rd_cnt;
      fork
         send(6, 1'b0, 1'b0);
      join_none
      repeat (5) @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_rd_en", ks_rd_en, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_one_pop", rd_cnt - r0, 1);
      rdy_val = 1'b1;
      @(posedge clk);
      #1;
      c = 0;
      repeat (5) begin
         @(negedge clk);
         if (ks_rd_en) c++;
      end
      check("bp_full_rate", c, 5);
      wait fork;
      drain();

      // Empty keystream buffer stalls the input.
      @(posedge clk);
      #1;
      force_empty = 1'b1;
      r0 = rd_cnt;
      fork
         send(2, 1'b0, 1'b0);
      join_none
      repeat (4) @(negedge clk);
      check("empty_in_ready", in_ready, 0);
      check("empty_rd_en", ks_rd_en, 0);
      check("empty_no_pop", rd_cnt - r0, 0);
      @(posedge clk);
      #1;
      force_empty = 1'b0;
      @(negedge clk);
      check("empty_release_rd", ks_rd_en, 1);
      wait fork;
      drain();

      // Randomized traffic with gaps and random backpressure.
      for (int s = 0; s < 3; s++) begin
         bp_en = 1'b1;
         do_start({$urandom, $urandom}, FW'($urandom), WPF_W'($urandom_range(0, 5)));
         send(40, 1'b0, 1'b1);
         bp_en = 1'b0;
         drain();
      end

      // start and stop together in RUN with a held word.
      rdy_val = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      send(1, 1'b0, 1'b0);
      check("ss_held", out_valid, 1);
      l0    = load_cnt;
      start = 1'b1;
      stop  = 1'b1;
      key   = {$urandom, $urandom};
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      check("ss_busy", busy, 0);
      check("ss_out_valid", out_valid, 1);
      @(negedge clk);
      check("ss_no_load", load_cnt - l0, 0);
      drain();

      // Asynchronous reset drops a held word immediately.
      rdy_val = 1'b0;
      do_start({$urandom, $urandom}, 22'h0F0, 8'd0);
      send(1, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_busy", busy, 0);
      check("arst_cur_frame", cur_frame, 0);
      check("arst_out_data", out_data, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
